char_buffer_dump: RTL

- Reader counterpart to the character-buffer init writer.
- Walks the 80x32 character buffer through the buffer's read port and streams its contents as 8-bit bytes over a valid/ready handshake.
- Output feeds the console UART transmitter, for screen dump or row dump to a host.
- Uses the same buffer address format, {col[6:0], row[4:0]}, and the same 7-bit character codes as the buffer writers.

---
 rtl/char_buffer_dump_if.sv | 30 +++
 rtl/char_buffer_dump.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/char_buffer_dump_if.sv
// Read-port and byte-stream bundle for char_buffer_dump.
// master = the dump engine, slave = buffer read port plus transmitter.
`timescale 1ns/1ps

interface char_buffer_dump_if;
  logic        rdEn;
  logic [11:0] rdAddress;
  logic [6:0]  rdData;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;

  modport master (
    output rdEn,
    output rdAddress,
    input  rdData,
    output txData,
    output txValid,
    input  txReady
  );

  modport slave (
    input  rdEn,
    input  rdAddress,
    output rdData,
    input  txData,
    input  txValid,
    output txReady
  );
endinterface

// File: rtl/char_buffer_dump.sv
// Streams the 80x32 character buffer (or a single row) as bytes to the console UART.
// Define DUMP_CRLF_EN to end rows with CR LF; by default rows end with LF only.
`timescale 1ns/1ps

module char_buffer_dump #(
  parameter int          MAXCOL    = 80,
  parameter int          MAXROW    = 32,
  parameter logic [7:0]  NUL_SUBST = 8'h20
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               rowOnly,
  input  logic [4:0]         dumpRow,
  char_buffer_dump_if.master bus,
  output logic               busy,
  output logic               done
);

  localparam logic [6:0] LAST_COL      = 7'(MAXCOL - 1);
  localparam logic [4:0] FULL_LAST_ROW = 5'(MAXROW - 1);
  localparam logic [7:0] BYTE_CR       = 8'h0D;
  localparam logic [7:0] BYTE_LF       = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
`ifdef DUMP_CRLF_EN
    EOL_CR,
`endif
    EOL_LF,
    FINISH
  } state_t;

  state_t     state, state_n;
  logic [6:0] col, col_n;
  logic [4:0] row, row_n;
  logic [4:0] last_row, last_row_n;
  logic [7:0] char_q, char_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      last_row <= '0;
      char_q   <= '0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      row      <= row_n;
      last_row <= last_row_n;
      char_q   <= char_n;
    end
  end

  // Walk order: all columns of a row, then the end-of-line bytes, then the next row.
  always_comb begin
    state_n    = state;
    col_n      = col;
    row_n      = row;
    last_row_n = last_row;
    char_n     = char_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = FETCH;
          col_n      = '0;
          row_n      = rowOnly ? dumpRow : 5'd0;
          last_row_n = rowOnly ? dumpRow : FULL_LAST_ROW;
        end
      end
      FETCH: state_n = WAIT;
      WAIT: begin
        char_n  = (bus.rdData == 7'd0) ? NUL_SUBST : {1'b0, bus.rdData};
        state_n = SEND;
      end
      SEND: begin
        if (bus.txReady) begin
          if (col == LAST_COL) begin
`ifdef DUMP_CRLF_EN
            state_n = EOL_CR;
`else
            state_n = EOL_LF;
`endif
          end else begin
            col_n   = col + 7'd1;
            state_n = FETCH;
          end
        end
      end
`ifdef DUMP_CRLF_EN
      EOL_CR: begin
        if (bus.txReady) state_n = EOL_LF;
      end
`endif
      EOL_LF: begin
        if (bus.txReady) begin
          if (row == last_row) begin
            state_n = FINISH;
          end else begin
            row_n   = row + 5'd1;
            col_n   = '0;
            state_n = FETCH;
          end
        end
      end
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // txValid follows the state register, so it drops on the handshake edge itself.
  always_comb begin
    bus.txValid = 1'b0;
    bus.txData  = 8'h00;
    case (state)
      SEND: begin
        bus.txValid = 1'b1;
        bus.txData  = char_q;
      end
`ifdef DUMP_CRLF_EN
      EOL_CR: begin
        bus.txValid = 1'b1;
        bus.txData  = BYTE_CR;
      end
`endif
      EOL_LF: begin
        bus.txValid = 1'b1;
        bus.txData  = BYTE_LF;
      end
      default: begin
        bus.txValid = 1'b0;
        bus.txData  = 8'h00;
      end
    endcase
  end

  assign bus.rdEn      = (state == FETCH);
  assign bus.rdAddress = {col, row};
  assign busy          = (state != IDLE);
  assign done          = (state == FINISH);

endmodule
